// File: rtl/dram_ctrl_pkg.sv
// Shared widths and controller state for the 32x1 LUT-RAM arbiter.
package dram_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    SERVE = 1'b1
  } state_t;

endpackage

// File: rtl/RAM32X1D.sv
// Behavioural model of the Xilinx RAM32X1D primitive: synchronous write port
// with async read (SPO) and an independent async read port (DPO).
module RAM32X1D #(
  parameter logic [31:0] INIT = 32'h0000_0000
) (
  output logic SPO,
  output logic DPO,
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic A4,
  input  logic D,
  input  logic DPRA0,
  input  logic DPRA1,
  input  logic DPRA2,
  input  logic DPRA3,
  input  logic DPRA4,
  input  logic WCLK,
  input  logic WE
);

  // Configuration-time contents; the LUT cells power up holding INIT.
  logic [31:0] mem = INIT;
  logic [4:0]  wa;
  logic [4:0]  ra;

  assign wa  = {A4, A3, A2, A1, A0};
  assign ra  = {DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};
  assign SPO = mem[wa];
  assign DPO = mem[ra];

  always_ff @(posedge WCLK) begin
    if (WE) mem[wa] <= D;
  end

endmodule

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grants, registered last-winner.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last;

  // On a tie the requester that did not win last time goes first.
  assign gnt0 = en & req0 & (~req1 | last);
  assign gnt1 = en & req1 & (~req0 | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (gnt0) last <= 1'b0;
    else if (gnt1) last <= 1'b1;
  end

endmodule

// File: rtl/dram_32x1d_arbiter.sv
// Clears a RAM32X1D after reset or on request, then serves single-bit
// accesses from two round-robin requesters on its read/write port.
module dram_32x1d_arbiter
  import dram_ctrl_pkg::*;
#(
  parameter logic [31:0] INIT      = 32'h0000_0000,
  parameter logic        CLEAR_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              wdata0,
  input  logic              wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              rdata,
  input  logic [ADDR_W-1:0] mon_addr,
  output logic              mon_data
);

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              clearing;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_d;
  logic              ram_we;
  logic              spo;

  assign clearing = (state == CLEAR);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (~clearing),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // The sweep owns the port while clearing; reset holds WE off so the
  // RAM is only rewritten by an actual sweep.
  always_comb begin
    ram_addr = addr0;
    ram_d    = wdata0;
    ram_we   = 1'b0;
    if (clearing) begin
      ram_addr = clr_addr;
      ram_d    = CLEAR_VAL;
      ram_we   = rst_n;
    end else if (gnt1) begin
      ram_addr = addr1;
      ram_d    = wdata1;
      ram_we   = we1;
    end else begin
      ram_we   = gnt0 & we0;
    end
  end

  RAM32X1D #(
    .INIT(INIT)
  ) u_ram (
    .SPO  (spo),
    .DPO  (mon_data),
    .A0   (ram_addr[0]),
    .A1   (ram_addr[1]),
    .A2   (ram_addr[2]),
    .A3   (ram_addr[3]),
    .A4   (ram_addr[4]),
    .D    (ram_d),
    .DPRA0(mon_addr[0]),
    .DPRA1(mon_addr[1]),
    .DPRA2(mon_addr[2]),
    .DPRA3(mon_addr[3]),
    .DPRA4(mon_addr[4]),
    .WCLK (clk),
    .WE   (ram_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 5'd1;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= SERVE;
            busy  <= 1'b0;
          end
        end
        SERVE: begin
          if (clr) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  // A read granted in the last SERVE cycle still gets its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0;
      rvalid1 <= gnt1 & ~we1;
      if ((gnt0 & ~we0) | (gnt1 & ~we1)) rdata <= spo;
    end
  end

endmodule
